// File: rtl/aoc2_pkg.sv
// Shared types, FSM states and the compile-time term table for the repeated-digit range summer.
// Table order: all exactly-twice (d = 2) entries first, so mode 0 walks a prefix of the mode-1 table.
package aoc2_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ACC_WIDTH  = 128;
  localparam int DEF_MAX_DIGITS = 19;

  typedef logic [DEF_DATA_WIDTH-1:0]       data_t;
  typedef logic signed [DEF_ACC_WIDTH-1:0] acc_t;

  typedef struct packed {
    data_t mult;
    data_t m_lo;
    data_t m_hi;
    logic  neg;
  } term_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DIV,
    ST_MUL,
    ST_ACC,
    ST_OUT
  } state_t;

  function automatic data_t pow10(input int e);
    data_t p;
    p = data_t'(1);
    for (int i = 0; i < e; i++) p = p * data_t'(10);
    return p;
  endfunction

  // Moebius function; zero once any prime divides d twice.
  function automatic int mobius(input int d);
    int n;
    int r;
    n = d;
    r = 1;
    for (int p = 2; p <= d; p++) begin
      if (n % p == 0) begin
        n = n / p;
        r = (n % p == 0) ? 0 : -r;
      end
    end
    return r;
  endfunction

  function automatic term_t make_term(input int digits, input int d);
    term_t t;
    int    k;
    k      = digits / d;
    t.mult = '0;
    for (int i = 0; i < d; i++) t.mult = t.mult + pow10(k * i);
    t.m_lo = pow10(k - 1);
    t.m_hi = pow10(k) - data_t'(1);
    t.neg  = (mobius(d) == 1);
    return t;
  endfunction

  function automatic term_t term_entry(input int idx, input int max_digits);
    term_t t;
    int    n;
    t = '0;
    n = 0;
    for (int digits = 2; digits <= max_digits; digits++) begin
      if (digits % 2 == 0) begin
        if (n == idx) t = make_term(digits, 2);
        n++;
      end
    end
    for (int digits = 2; digits <= max_digits; digits++) begin
      for (int d = 3; d <= digits; d++) begin
        if ((digits % d == 0) && (mobius(d) != 0)) begin
          if (n == idx) t = make_term(digits, d);
          n++;
        end
      end
    end
    return t;
  endfunction

  function automatic int term_count(input logic mode, input int max_digits);
    int n;
    n = 0;
    for (int digits = 2; digits <= max_digits; digits++) begin
      if (digits % 2 == 0) n++;
      if (mode) begin
        for (int d = 3; d <= digits; d++) begin
          if ((digits % d == 0) && (mobius(d) != 0)) n++;
        end
      end
    end
    return n;
  endfunction

  localparam int NT0 = term_count(1'b0, DEF_MAX_DIGITS);
  localparam int NT1 = term_count(1'b1, DEF_MAX_DIGITS);

endpackage

// File: rtl/udiv_seq.sv
// Restoring unsigned divider: the start edge performs the first quotient bit, so done is
// high exactly WIDTH cycles after start with the quotient already final.
module udiv_seq
  import aoc2_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] rem_src, quo_src, div_src, rem_nx, quo_nx;
  logic [WIDTH:0]   trial;

  always_comb begin
    rem_src = start ? '0 : rem_q;
    quo_src = start ? dividend : quo_q;
    div_src = start ? divisor : div_q;
    trial   = {rem_src, quo_src[WIDTH-1]};
    if (trial >= {1'b0, div_src}) begin
      rem_nx = WIDTH'(trial - {1'b0, div_src});
      quo_nx = {quo_src[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo_src[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= rem_nx;
      quo_q  <= quo_nx;
      div_q  <= divisor;
      cnt_q  <= CW'(WIDTH - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q - CW'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done     = busy_q && (cnt_q == '0);
  assign quotient = quo_q;

endmodule

// File: rtl/repid_range_sum.sv
// Sums repeated-digit IDs in [lo, hi] as F(hi) - F(lo-1), one inclusion-exclusion term at a time.
// Latency is fixed: every term of both passes always runs, degenerate cases only zero the result.
module repid_range_sum
  import aoc2_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_DIGITS = DEF_MAX_DIGITS,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] lo_in,
  input  logic [DATA_WIDTH-1:0] hi_in,
  input  logic                  mode_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  sum_out
);

  localparam int NT_M0 = term_count(1'b0, MAX_DIGITS);
  localparam int NT_M1 = term_count(1'b1, MAX_DIGITS);
  localparam int IW    = $clog2(NT_M1);

  term_t term_tab [NT_M1];

  for (genvar g = 0; g < NT_M1; g++) begin : g_tab
    localparam term_t ENTRY = term_entry(g, MAX_DIGITS);
    assign term_tab[g] = ENTRY;
  end

  state_t                     state_q, state_d;
  logic [DATA_WIDTH-1:0]      lo_q, hi_q;
  logic                       mode_q, pass_b_q, out_valid_q;
  logic [IW-1:0]              idx_q;
  term_t                      term_q;
  logic [ACC_WIDTH-1:0]       prod_q, sum_q;
  logic signed [ACC_WIDTH-1:0] acc_q;

  logic                  div_start, div_done, last_term, in_span;
  logic [DATA_WIDTH-1:0] div_n, div_m, quotient;
  logic [DATA_WIDTH-1:0] m_mult, m_lo, m_hi, top_val;
  logic [ACC_WIDTH-1:0]  pair_prod, term_val;

  assign div_start = (state_q == ST_SETUP);
  assign div_n     = pass_b_q ? lo_q - DATA_WIDTH'(1) : hi_q;
  assign div_m     = DATA_WIDTH'(term_tab[idx_q].mult);
  assign last_term = (idx_q == (mode_q ? IW'(NT_M1 - 1) : IW'(NT_M0 - 1)));

  udiv_seq #(.WIDTH(DATA_WIDTH)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_n),
    .divisor  (div_m),
    .quotient (quotient),
    .done     (div_done)
  );

  // Clip the block count to the k-digit range; the consecutive-parity pair is even, so halve after the product.
  always_comb begin
    m_mult    = DATA_WIDTH'(term_q.mult);
    m_lo      = DATA_WIDTH'(term_q.m_lo);
    m_hi      = DATA_WIDTH'(term_q.m_hi);
    top_val   = (quotient > m_hi) ? m_hi : quotient;
    in_span   = (top_val >= m_lo) && !(pass_b_q && (lo_q == '0));
    pair_prod = (ACC_WIDTH'(top_val) + ACC_WIDTH'(m_lo)) *
                (ACC_WIDTH'(top_val - m_lo) + ACC_WIDTH'(1));
    term_val  = ACC_WIDTH'(m_mult) * (pair_prod >> 1);
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_SETUP;
      ST_SETUP: state_d = ST_DIV;
      ST_DIV:   if (div_done) state_d = ST_MUL;
      ST_MUL:   state_d = ST_ACC;
      ST_ACC:   state_d = (last_term && pass_b_q) ? ST_OUT : ST_SETUP;
      ST_OUT:   if (out_valid_q && out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The first OUT cycle registers the result, which is why out_valid trails the final ACC by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      lo_q        <= '0;
      hi_q        <= '0;
      mode_q      <= 1'b0;
      pass_b_q    <= 1'b0;
      idx_q       <= '0;
      term_q      <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            lo_q     <= lo_in;
            hi_q     <= hi_in;
            mode_q   <= mode_in;
            pass_b_q <= 1'b0;
            idx_q    <= '0;
            acc_q    <= '0;
          end
        end
        ST_SETUP: term_q <= term_tab[idx_q];
        ST_MUL:   prod_q <= in_span ? term_val : '0;
        ST_ACC: begin
          if (term_q.neg ^ pass_b_q) acc_q <= acc_q - $signed(prod_q);
          else                       acc_q <= acc_q + $signed(prod_q);
          if (last_term) begin
            pass_b_q <= 1'b1;
            idx_q    <= '0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_OUT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            sum_q       <= (lo_q > hi_q) ? '0 : $unsigned(acc_q);
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign sum_out   = sum_q;

endmodule

// File: tb/tb_repid_range_sum.sv
// Directed and randomized checks of repid_range_sum against a brute-force string-based model
// of repeated-digit IDs, including fixed latency, output stall, back-to-back and mid-run reset.
module tb_repid_range_sum;

  localparam int DW     = 64;
  localparam int AW     = 128;
  localparam int T_TERM = DW + 3;
  localparam int NT0    = 9;
  localparam int NT1    = 30;
  localparam longint unsigned MAXV = 64'd9999999999999999999;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] lo_in;
  logic [DW-1:0] hi_in;
  logic          mode_in;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] sum_out;

  int errors;
  int checks;

  repid_range_sum dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lo_in     (lo_in),
    .hi_in     (hi_in),
    .mode_in   (mode_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A number qualifies when its decimal string is some block repeated (exactly twice in mode 0).
  function automatic bit is_rep(input longint unsigned n, input bit mode);
    string s;
    int    len;
    bit    hit;
    s   = $sformatf("%0d", n);
    len = s.len();
    hit = 1'b0;
    for (int k = 1; k <= len / 2; k++) begin
      if ((len % k == 0) && (mode || (len == 2 * k))) begin
        bit same;
        same = 1'b1;
        for (int i = k; i < len; i++) if (s[i] != s[i-k]) same = 1'b0;
        if (same) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  function automatic logic [AW-1:0] model_sum(input longint unsigned lo, input longint unsigned hi,
                                              input bit mode);
    logic [AW-1:0] s;
    s = '0;
    for (longint unsigned n = lo; n <= hi; n++) if (is_rep(n, mode)) s = s + AW'(n);
    return s;
  endfunction

  function automatic int exp_latency(input bit mode);
    return 2 * (mode ? NT1 : NT0) * T_TERM + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one request, scrambles the inputs after acceptance, and waits for out_valid.
  task automatic applyStimulus(input string tag, input longint unsigned lo, input longint unsigned hi,
                               input bit mode, output logic [AW-1:0] res, output int lat);
    int waited;
    waited = 0;
    @(negedge clock);
    while (!in_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    checkOutput({tag, "_ready"}, AW'(in_ready), AW'(1));
    lo_in    = lo;
    hi_in    = hi;
    mode_in  = mode;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lo_in    = '1;
    hi_in    = '0;
    mode_in  = ~mode;
    lat      = 0;
    while (lat < 6000) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (out_valid) break;
    end
    res = sum_out;
  endtask

  task automatic runRequest(input string tag, input longint unsigned lo, input longint unsigned hi,
                            input bit mode, input logic [AW-1:0] exp);
    logic [AW-1:0] res;
    int            lat;
    applyStimulus(tag, lo, hi, mode, res, lat);
    checkOutput({tag, "_sum"}, res, exp);
    checkOutput({tag, "_latency"}, AW'(lat), AW'(exp_latency(mode)));
    @(posedge clock);
    @(negedge clock);
    checkOutput({tag, "_valid_drop"}, AW'(out_valid), AW'(0));
    checkOutput({tag, "_ready_back"}, AW'(in_ready), AW'(1));
  endtask

  initial begin
    logic [AW-1:0] res;
    int            lat;
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    lo_in     = '0;
    hi_in     = '0;
    mode_in   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("reset_in_ready", AW'(in_ready), AW'(1));
    checkOutput("reset_out_valid", AW'(out_valid), AW'(0));
    checkOutput("reset_sum", sum_out, '0);

    runRequest("m0_11_22", 11, 22, 1'b0, 33);
    runRequest("m1_95_115", 95, 115, 1'b1, 210);
    runRequest("m0_95_115", 95, 115, 1'b0, 99);
    runRequest("m0_998_1012", 998, 1012, 1'b0, 1010);
    runRequest("m1_998_1012", 998, 1012, 1'b1, 2009);
    runRequest("m0_big", 64'd1188511880, 64'd1188511890, 1'b0, 1188511885);
    runRequest("m1_dedup", 222220, 222224, 1'b1, 222222);
    runRequest("m1_1_9", 1, 9, 1'b1, 0);
    runRequest("m0_0_0", 0, 0, 1'b0, 0);
    runRequest("m1_lo_gt_hi", 50, 10, 1'b1, 0);
    runRequest("m0_0_100", 0, 100, 1'b0, 495);

    // Consumer stalls: result must hold and no new request may be taken.
    out_ready = 1'b0;
    applyStimulus("stall", 11, 99, 1'b0, res, lat);
    checkOutput("stall_sum", res, 495);
    checkOutput("stall_latency", AW'(lat), AW'(exp_latency(1'b0)));
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checkOutput("stall_valid", AW'(out_valid), AW'(1));
      checkOutput("stall_hold", sum_out, 495);
      checkOutput("stall_in_ready", AW'(in_ready), AW'(0));
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("stall_release_valid", AW'(out_valid), AW'(0));
    checkOutput("stall_release_ready", AW'(in_ready), AW'(1));

    runRequest("b2b_a", 1000, 2000, 1'b0, model_sum(1000, 2000, 1'b0));
    runRequest("b2b_b", 100, 1000, 1'b1, model_sum(100, 1000, 1'b1));

    // Reset during the first divide of pass A discards the request.
    @(negedge clock);
    lo_in    = 10;
    hi_in    = 99;
    mode_in  = 1'b0;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("midrst_out_valid", AW'(out_valid), AW'(0));
    checkOutput("midrst_in_ready", AW'(in_ready), AW'(1));
    checkOutput("midrst_sum", sum_out, '0);
    repeat (100) @(negedge clock);
    checkOutput("midrst_quiet", AW'(out_valid), AW'(0));
    runRequest("after_reset", 11, 22, 1'b0, 33);

    for (int r = 0; r < 6; r++) begin
      bit              m;
      int              digits;
      int              k;
      longint unsigned p;
      longint unsigned blk;
      longint unsigned x;
      longint unsigned lo;
      longint unsigned hi;
      longint unsigned offs;
      m = r[0];
      if (!m) begin
        digits = 2 * $urandom_range(9, 1);
        k      = digits / 2;
      end else begin
        digits = $urandom_range(19, 2);
        do k = $urandom_range(digits / 2, 1); while (digits % k != 0);
      end
      p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
      blk = p / 10 + (longint'($urandom) % (p - p / 10));
      x   = 0;
      for (int i = 0; i < digits / k; i++) x = x * p + blk;
      offs = $urandom_range(300, 0);
      lo   = (x < offs) ? 0 : x - offs;
      hi   = x + $urandom_range(300, 0);
      if (hi > MAXV) hi = MAXV;
      $display("[TB] random %0d: mode=%0d lo=%0d hi=%0d", r, m, lo, hi);
      runRequest($sformatf("rand%0d", r), lo, hi, m, model_sum(lo, hi, m));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/repid_range_sum.md
# repid_range_sum

Computes the sum of all repeated-digit IDs (decimal numbers formed by a k-digit block repeated r ≥ 2 times) lying in an inclusive range [lo, hi]. Parametrised successor of the single-bound counter: it accepts a whole range over a valid/ready handshake, evaluates F(hi) − F(lo−1) internally, and supports two modes: exactly-twice repeats (mode 0) and any repeat count ≥ 2 with no double counting (mode 1). Sits between the input-parsing front end and the cumulative-sum accumulator.

## Interface
- DATA_WIDTH, 64: width of range bounds and divider.
- MAX_DIGITS, 19: largest decimal digit count handled; 10^MAX_DIGITS − 1 must fit in DATA_WIDTH.
- ACC_WIDTH, 128: signed accumulator and result width; ≥ 2*DATA_WIDTH.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  range request valid.
- in_ready  out  1  block idle, can accept.
- lo_in  in  DATA_WIDTH  inclusive lower bound.
- hi_in  in  DATA_WIDTH  inclusive upper bound.
- mode_in  in  1  0 = exactly two repeats, 1 = two or more repeats.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer accepts result.
- sum_out  out  ACC_WIDTH  sum of qualifying IDs in [lo, hi]; unsigned value, top bit always 0.

## Operation
- Term table (compile-time): for each digit count D in 2..MAX_DIGITS and each squarefree divisor d > 1 of D, an entry {k = D/d, M = Σ_{i<d} 10^(k·i), m_lo = 10^(k−1), m_hi = 10^k − 1, sign = −μ(d), mode1 flag}. Mode 0 uses only entries with d = 2 (sign +); mode 1 uses all. MAX_DIGITS = 19: NT(0) = 9, NT(1) = 30.
- Term contribution for bound n: q = floor(n / M); top = min(q, m_hi); if top < m_lo contribute 0, else contribute sign · M · (m_lo + top)(top − m_lo + 1)/2. The halving is exact (product of consecutive-parity pair); multiply at full width before the shift.
- Pass A evaluates n = hi with sign +1; pass B evaluates n = lo − 1 with sign −1. If lo = 0, pass B still runs with its contributions forced to 0 (constant latency).
- If lo > hi: both passes run, result forced to 0.
- FSM: IDLE → SETUP (latch term entry, start divider) → DIV (wait for divider done) → MUL (clip, product) → ACC (signed add) → SETUP of next term, or pass B, or OUT. OUT holds out_valid until out_ready, then IDLE.
- in_ready = 1 only in IDLE; request accepted on in_valid & in_ready; lo/hi/mode registered at acceptance, inputs ignored afterwards.
- Reset at any time: state IDLE, accumulator cleared, divider aborted, in_ready = 1 on the first cycle after reset deasserts, out_valid = 0, sum_out = 0. No in-flight result survives.

## Timing
- Reset values: in_ready 1 (after reset release), out_valid 0, sum_out 0.
- Per term: exactly T_TERM = DATA_WIDTH + 3 cycles (SETUP 1, DIV DATA_WIDTH, MUL 1, ACC 1).
- Acceptance edge to out_valid rise: 2·NT(mode)·T_TERM + 1 cycles, independent of operand values.
- out_valid and sum_out stable while out_ready low; handshake completes on out_valid & out_ready; in_ready rises the next cycle (no same-cycle accept of a new request).

## Structure
- Package aoc2_pkg: DATA_WIDTH/ACC_WIDTH typedefs, term_t struct, term-table generation function (powers of ten, M, μ), NT(mode) constants, FSM state enum.
- Sub-module udiv_seq: restoring unsigned divider, DATA_WIDTH quotient bits, start/done pulse, fixed DATA_WIDTH cycles, synchronous abort on reset.

## Test plan
- Mode 0, [11, 22] → 33; mode 1, [95, 115] → 210 (99 + 111); mode 0 same range → 99.
- Mode 0 and mode 1, [998, 1012] → 1010 and 2009 respectively; [1188511880, 1188511890] mode 0 → 1188511885.
- Dedup: mode 1, [222220, 222224] → 222222 (counted once despite periods 1, 2, 3); mode 1, [1, 9] → 0.
- Edges: [0, 0] → 0; lo > hi ([50, 10]) → 0; lo = 0, hi = 100, mode 0 → 495; latency equals 2·NT·T_TERM + 1 in every case.
- Handshake: hold out_ready low 20 cycles → out_valid and sum_out stable, in_ready low; release → in_ready high next cycle; back-to-back requests each correct.
- Reset asserted mid-DIV of pass A → out_valid 0, in_ready 1 after release; following request returns correct sum; full puzzle input through mode 0 matches golden total 49046150754.
